uart_mmio_responder: RTL and testbench
======================================

// Module: uart_mmio_responder
// PURPOSE
//   Peripheral-side responder for CPU load/store accesses in the peripheral window (is_peri decode).
//   Provides buffered UART transmit and receive with TX and RX FIFOs, plus a status register.
//   Drives the uart_tx byte handshake and absorbs uart_rx byte strobes.
//   Replaces ad-hoc UART glue in the SoC top; the CPU polls status instead of racing single-byte latches.
// PARAMETERS
//   FIFO_DEPTH  8      entries per FIFO; power of two, 2..8
//   ADDR_TXD    8'h18  byte offset of TX data register (write-only)
//   ADDR_RXD    8'h1C  byte offset of RX data register (read-pops)
//   ADDR_STAT   8'h20  byte offset of status register (read; write-1-to-clear sticky bits)
// PORTS
//   clk         in   1   single clock, all state on posedge
//   reset_n     in   1   synchronous, active-low reset
//   sel         in   1   access targets peripheral window
//   addr        in   8   physical address [7:0]
//   we          in   1   store strobe (qualified by sel)
//   re          in   1   load strobe (qualified by sel)
//   wdata       in   32  store data
//   rdata       out  32  load data, registered
//   tx_dv       out  1   one-cycle start pulse to uart_tx
//   tx_byte     out  8   byte to uart_tx, held stable from tx_dv until tx_done
//   tx_done     in   1   one-cycle pulse from uart_tx at end of stop bit
//   rx_dv       in   1   one-cycle pulse from uart_rx, byte valid
//   rx_byte     in   8   received byte
//   irq_rx      out  1   level: RX FIFO non-empty
// BEHAVIOUR
//   Clock and reset: one clock; reset is synchronous and active-low.
//   Reset: rdata=0, tx_dv=0, tx_byte=0, irq_rx=0; both FIFOs empty; sticky bits 0; TX FSM in IDLE.
//   Reset mid-frame: tx_dv is deasserted and the FIFOs are flushed. A later tx_done from a frame
//     already in flight is ignored in IDLE.
//   Access: act only when sel && (we || re). we && re in the same cycle: we wins, no read side effect.
//   TXD write: push wdata[7:0]. If the TX FIFO is full, the byte is dropped and tx_drop is set.
//   RXD read: next-cycle rdata={24'b0, head}, and the head is popped. If empty, rdata=0 and no pop.
//   STAT read: next-cycle rdata fields:
//     [0]     tx_full
//     [1]     tx_empty
//     [2]     rx_valid
//     [3]     tx_busy (FSM != IDLE or TX FIFO non-empty)
//     [4]     rx_overrun
//     [5]     tx_drop
//     [11:8]  tx_count
//     [19:16] rx_count
//     other bits 0.
//   STAT write: wdata[4]=1 clears rx_overrun; wdata[5]=1 clears tx_drop.
//     A set event in the same cycle as a clear wins (the bit stays 1).
//   Read latency: 1 cycle. rdata holds its value when there is no read.
//     Reads of unmapped offsets, and reads of TXD, return 0.
//   RX path: rx_dv pushes rx_byte.
//     If full and no same-cycle pop: the byte is dropped and rx_overrun is set.
//     If full with a same-cycle CPU pop: the push is accepted and the count is unchanged.
//   FIFO counts: 0..FIFO_DEPTH (width clog2(FIFO_DEPTH)+1, zero-extended into the field).
//     Pointers wrap modulo FIFO_DEPTH.
//   Simultaneous push and pop on a non-empty FIFO: both occur, count unchanged.
//   TX FSM:
//     IDLE -> LOAD when the TX FIFO is non-empty.
//     LOAD: pop the head into tx_byte and assert tx_dv for exactly 1 cycle; -> WAIT.
//     WAIT: hold tx_byte; on tx_done -> IDLE.
//   Back-to-back frames: the next tx_dv comes no earlier than 2 cycles after tx_done.
//   irq_rx is registered from FIFO state and updates 1 cycle after a push or pop.
// TESTING
//   Reset: hold reset_n=0 for 3 cycles with rx_dv toggling -> all outputs 0; STAT reads 0x00000002.
//   TX order: write 0x41, 0x42, 0x43 to TXD; model tx_done 20 cycles after each tx_dv
//     -> tx_byte sequence 41, 42, 43; tx_dv single-cycle; tx_busy clears after the last tx_done.
//   TX overflow: 9 TXD writes with tx_done withheld -> 1 in flight + 8 queued; 9th write accepted.
//     10th write dropped; STAT reads tx_drop=1, tx_count=8.
//   RX overflow: 9 rx_dv pulses (bytes 0..8) with no reads -> rx_overrun=1, rx_count=8.
//     RXD reads return 0..7 in order, then 0 when empty; irq_rx falls 1 cycle after the 8th pop.
//   Simultaneous events: rx_dv on a full FIFO in the same cycle as an RXD read -> pop returns the old head.
//     Push accepted, rx_count stays 8, no overrun. STAT W1C 0x30 in the same cycle as an overrun -> bit stays 1.
//   Mid-frame reset: reset_n=0 during WAIT -> tx_dv=0, FIFOs empty.
//     A stray tx_done after release does not pop or pulse tx_dv.

Source files
------------

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: MMIO UART responder with TX/RX FIFOs, status register and uart_tx handshake FSM.
module uart_mmio_responder #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] ADDR_TXD   = 8'h18,
  parameter logic [7:0] ADDR_RXD   = 8'h1C,
  parameter logic [7:0] ADDR_STAT  = 8'h20
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        sel_i,
  input  logic [7:0]  addr_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_dv_o,
  output logic [7:0]  tx_byte_o,
  input  logic        tx_done_i,
  input  logic        rx_dv_i,
  input  logic [7:0]  rx_byte_i,
  output logic        irq_rx_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} tx_state_e;
  tx_state_e     state_q, state_d;
  logic [7:0]    tx_mem_q [FIFO_DEPTH];
  logic [7:0]    rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [31:0]   rdata_q, rdata_d, stat_v;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_dv_q, irq_q, ovr_q, ovr_d, drop_q, drop_d;
  logic          wr_acc, rd_acc, tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop, stat_clr;
  logic          unused_wdata;
  assign unused_wdata = ^wdata_i[31:8];
  always_comb begin
    wr_acc   = sel_i & we_i;
    rd_acc   = sel_i & re_i & ~we_i;
    tx_full  = tx_cnt_q == FULL;
    tx_empty = tx_cnt_q == '0;
    rx_full  = rx_cnt_q == FULL;
    rx_empty = rx_cnt_q == '0;
    tx_push  = wr_acc & (addr_i == ADDR_TXD) & ~tx_full;
    tx_pop   = (state_q == LOAD) & ~tx_empty;
    rx_pop   = rd_acc & (addr_i == ADDR_RXD) & ~rx_empty;
    // a full RX FIFO still takes the byte when the CPU frees a slot this cycle
    rx_push  = rx_dv_i & (~rx_full | rx_pop);
    stat_clr = wr_acc & (addr_i == ADDR_STAT);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    ovr_d    = (rx_dv_i & rx_full & ~rx_pop) | (ovr_q & ~(stat_clr & wdata_i[4]));
    drop_d   = (wr_acc & (addr_i == ADDR_TXD) & tx_full) | (drop_q & ~(stat_clr & wdata_i[5]));
    stat_v          = '0;
    stat_v[0]       = tx_full;
    stat_v[1]       = tx_empty;
    stat_v[2]       = ~rx_empty;
    stat_v[3]       = (state_q != IDLE) | ~tx_empty;
    stat_v[4]       = ovr_q;
    stat_v[5]       = drop_q;
    stat_v[8 +: CW] = tx_cnt_q;
    stat_v[16 +: CW] = rx_cnt_q;
    rdata_d  = ~rd_acc ? rdata_q :
               (addr_i == ADDR_RXD)  ? {24'b0, rx_empty ? 8'h00 : rx_mem_q[rx_rd_q]} :
               (addr_i == ADDR_STAT) ? stat_v : '0;
    state_d  = (state_q == IDLE) ? (tx_empty ? IDLE : LOAD) :
               (state_q == LOAD) ? WAIT :
               (tx_done_i ? IDLE : WAIT);
    tx_byte_d = tx_pop ? tx_mem_q[tx_rd_q] : tx_byte_q;
  end
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= wdata_i[7:0];
    if (rx_push) rx_mem_q[rx_wr_q] <= rx_byte_i;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      rdata_q   <= '0;
      tx_byte_q <= '0;
      tx_dv_q   <= 1'b0;
      irq_q     <= 1'b0;
      ovr_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_wr_q   <= tx_wr_q + AW'(tx_push);
      tx_rd_q   <= tx_rd_q + AW'(tx_pop);
      rx_wr_q   <= rx_wr_q + AW'(rx_push);
      rx_rd_q   <= rx_rd_q + AW'(rx_pop);
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      rdata_q   <= rdata_d;
      tx_byte_q <= tx_byte_d;
      tx_dv_q   <= tx_pop;
      irq_q     <= rx_cnt_d != '0;
      ovr_q     <= ovr_d;
      drop_q    <= drop_d;
    end
  end
  assign rdata_o   = rdata_q;
  assign tx_dv_o   = tx_dv_q;
  assign tx_byte_o = tx_byte_q;
  assign irq_rx_o  = irq_q;
endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb_uart_mmio_responder: directed vector table plus hand-written TX/RX corner sequences.
module tb_uart_mmio_responder;
  localparam logic [7:0] TXD = 8'h18, RXD = 8'h1C, STAT = 8'h20;
  logic        clk_i = 1'b0, reset_n_i = 1'b0, sel_i = 1'b0, we_i = 1'b0, re_i = 1'b0;
  logic [7:0]  addr_i = '0, rx_byte_i = '0;
  logic [31:0] wdata_i = '0;
  logic        tx_done_i = 1'b0, rx_dv_i = 1'b0;
  logic [31:0] rdata_o;
  logic        tx_dv_o, irq_rx_o;
  logic [7:0]  tx_byte_o;
  int total = 0, bad = 0;
  uart_mmio_responder dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .sel_i(sel_i), .addr_i(addr_i), .we_i(we_i),
    .re_i(re_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .tx_dv_o(tx_dv_o),
    .tx_byte_o(tx_byte_o), .tx_done_i(tx_done_i), .rx_dv_i(rx_dv_i),
    .rx_byte_i(rx_byte_i), .irq_rx_o(irq_rx_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic sel, we, re;
    logic [7:0] addr;
    logic [31:0] wdata;
    logic rxdv;
    logic [7:0] rxb;
    logic [31:0] exp_rd;
    logic exp_irq;
  } vec_t;
  vec_t v [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step(input logic s, input logic w, input logic r, input logic [7:0] a,
                      input logic [31:0] d, input logic dv, input logic [7:0] b);
    sel_i = s; we_i = w; re_i = r; addr_i = a; wdata_i = d; rx_dv_i = dv; rx_byte_i = b;
    @(posedge clk_i); #1;
    sel_i = 0; we_i = 0; re_i = 0; addr_i = '0; wdata_i = '0; rx_dv_i = 0; rx_byte_i = '0;
  endtask
  task automatic idle();
    step(0, 0, 0, 8'h0, 0, 0, 8'h0);
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step(1, 1, 0, a, d, 0, 8'h0);
  endtask
  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    step(1, 0, 1, a, 0, 0, 8'h0);
    d = rdata_o;
  endtask
  initial begin
    logic [31:0] r;
    logic [7:0] bytes [3];
    int n, wcnt, dvs;
    logic prev_dv, got;
    v[0]  = '{1, 0, 1, STAT, 0, 0, 8'h00, 32'h0000_0002, 0};
    v[1]  = '{0, 0, 0, 8'h00, 0, 1, 8'h5A, 32'h0000_0002, 1};
    v[2]  = '{1, 0, 1, STAT, 0, 0, 8'h00, 32'h0001_0006, 1};
    v[3]  = '{1, 0, 1, TXD, 0, 0, 8'h00, 32'h0, 1};
    v[4]  = '{1, 0, 1, 8'h00, 0, 0, 8'h00, 32'h0, 1};
    v[5]  = '{0, 0, 0, 8'h00, 0, 1, 8'hA5, 32'h0, 1};
    v[6]  = '{1, 0, 1, RXD, 0, 0, 8'h00, 32'h5A, 1};
    v[7]  = '{1, 1, 1, RXD, 32'hFF, 0, 8'h00, 32'h5A, 1};
    v[8]  = '{1, 0, 1, RXD, 0, 0, 8'h00, 32'hA5, 0};
    v[9]  = '{1, 0, 1, RXD, 0, 0, 8'h00, 32'h0, 0};
    v[10] = '{0, 0, 1, STAT, 0, 1, 8'h11, 32'h0, 1};
    v[11] = '{1, 0, 1, RXD, 0, 0, 8'h00, 32'h11, 0};
    reset_n_i = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h0, 0, i[0] == 1'b0, 8'hEE);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_outs", {tx_dv_o, tx_byte_o, irq_rx_o}, 0);
    reset_n_i = 1;
    for (int i = 0; i < 12; i++) begin
      step(v[i].sel, v[i].we, v[i].re, v[i].addr, v[i].wdata, v[i].rxdv, v[i].rxb);
      chk($sformatf("vec%0d_rdata", i), rdata_o, v[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'b0, irq_rx_o}, {31'b0, v[i].exp_irq});
    end
    wr(TXD, 32'h41); wr(TXD, 32'h42); wr(TXD, 32'h43);
    n = 0; wcnt = 0; prev_dv = 0;
    for (int i = 0; i < 150; i++) begin
      tx_done_i = 0;
      if (tx_dv_o) begin
        chk("tx_dv_spacing", {30'b0, prev_dv, wcnt != 0}, 0);
        if (n < 3) bytes[n] = tx_byte_o;
        n++;
        wcnt = 20;
      end else if (wcnt > 0) begin
        chk("tx_hold", {24'b0, tx_byte_o}, {24'b0, bytes[(n > 3 ? 3 : n) - 1]});
        wcnt--;
        if (wcnt == 0) tx_done_i = 1;
      end
      prev_dv = tx_dv_o;
      @(posedge clk_i); #1;
    end
    tx_done_i = 0;
    chk("tx_frames", n, 3);
    chk("tx_bytes", {8'h0, bytes[0], bytes[1], bytes[2]}, 32'h0041_4243);
    rd(STAT, r); chk("tx_busy_clear", r, 32'h0000_0002);
    wr(TXD, 32'h01);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) if (tx_dv_o) got = 1; else idle();
    chk("ovf_first_dv", {31'b0, got}, 1);
    for (int i = 2; i <= 9; i++) wr(TXD, i);
    rd(STAT, r); chk("ovf_stat_full", r, 32'h0000_0809);
    wr(TXD, 32'h0A);
    rd(STAT, r); chk("ovf_stat_drop", r, 32'h0000_0829);
    wr(STAT, 32'h20);
    rd(STAT, r); chk("ovf_w1c_drop", r, 32'h0000_0809);
    reset_n_i = 0;
    idle(); idle();
    chk("midrst_outs", {tx_dv_o, tx_byte_o, irq_rx_o}, 0);
    reset_n_i = 1;
    idle();
    tx_done_i = 1; idle(); tx_done_i = 0;
    dvs = 0;
    for (int i = 0; i < 6; i++) begin dvs += tx_dv_o; idle(); end
    chk("midrst_no_dv", dvs, 0);
    rd(STAT, r); chk("midrst_stat", r, 32'h0000_0002);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 8'h0, 0, 1, i[7:0]);
    rd(STAT, r); chk("rx_full_stat", r, 32'h0008_0006);
    step(1, 0, 1, RXD, 0, 1, 8'h99);
    chk("rx_simul_pop", rdata_o, 0);
    rd(STAT, r); chk("rx_simul_stat", r, 32'h0008_0006);
    step(1, 1, 0, STAT, 32'h30, 1, 8'hAA);
    rd(STAT, r); chk("rx_ovr_wins", r, 32'h0008_0016);
    wr(STAT, 32'h10);
    rd(STAT, r); chk("rx_ovr_w1c", r, 32'h0008_0006);
    for (int i = 1; i <= 8; i++) begin
      rd(RXD, r);
      chk($sformatf("rx_pop%0d", i), r, (i == 8) ? 32'h99 : i);
      chk($sformatf("rx_irq%0d", i), {31'b0, irq_rx_o}, {31'b0, i != 8});
    end
    rd(RXD, r); chk("rx_empty_read", r, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
